// File: rtl/hwpe_stream_pipe_pkg.sv
// hwpe_stream_package: shared types for the elastic stream pipe
package hwpe_stream_package;
    typedef enum logic {HWPE_STREAM_PIPE_FWD, HWPE_STREAM_PIPE_SKID} hwpe_stream_pipe_mode_t;
    typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_state_t;
    localparam int unsigned HWPE_STREAM_PIPE_MAX_STAGES = 8;
endpackage

// File: rtl/hwpe_stream_pipe_if.sv
// hwpe_stream_intf_stream: valid/ready stream with byte strobes
//  source: drives valid, data, strb; receives ready
//  sink:   receives valid, data, strb; drives ready
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    modport source(output valid, data, strb, input ready);
    modport sink(input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_pipe_stage.sv
// hwpe_stream_pipe_stage: one elastic register slice (FWD: 1 entry, SKID: 2 entries)
//  clk_i, rst_ni (async, active low), clear_i (sync flush)
//  in_valid/in_data/in_strb -> in_ready : upstream side
//  out_valid/out_data/out_strb <- out_ready : downstream side
//  empty : slice holds no beat (registered-derived)
module hwpe_stream_pipe_stage
    import hwpe_stream_package::*;
#(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter hwpe_stream_pipe_mode_t PIPE_MODE  = HWPE_STREAM_PIPE_FWD
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_strb,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [DATA_WIDTH/8-1:0] out_strb,
    input  logic                    out_ready,
    output logic                    empty
);
    localparam int unsigned SW = DATA_WIDTH / 8;
    if (PIPE_MODE == HWPE_STREAM_PIPE_FWD) begin : g_fwd
        logic            full_q;
        logic [DATA_WIDTH-1:0] data_q;
        logic [SW-1:0]   strb_q;
        // ready passes through combinationally so a full slice can refill while draining
        assign in_ready  = !clear_i && (!full_q || out_ready);
        assign out_valid = !clear_i && full_q;
        assign out_data  = data_q;
        assign out_strb  = strb_q;
        assign empty     = !full_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni || clear_i) begin
                full_q <= 1'b0;
                data_q <= '0;
                strb_q <= '0;
            end else if (in_valid && in_ready) begin
                full_q <= 1'b1;
                data_q <= in_data;
                strb_q <= in_strb;
            end else if (out_ready) begin
                full_q <= 1'b0;
            end
        end
    end else begin : g_skid
        skid_state_t     state_q, state_d;
        logic [DATA_WIDTH-1:0] main_q, skid_q;
        logic [SW-1:0]   main_strb_q, skid_strb_q;
        logic            accept, pop, load_main, load_skid, from_skid;
        // in_ready comes from the state flop only, so no path from out_ready to in_ready
        assign in_ready  = !clear_i && state_q != SKID_TWO;
        assign out_valid = !clear_i && state_q != SKID_EMPTY;
        assign out_data  = main_q;
        assign out_strb  = main_strb_q;
        assign empty     = state_q == SKID_EMPTY;
        assign accept    = in_valid && in_ready;
        assign pop       = out_valid && out_ready;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) state_q <= SKID_EMPTY;
            else         state_q <= state_d;
        end
        always_comb begin
            state_d   = state_q;
            load_main = 1'b0;
            load_skid = 1'b0;
            from_skid = 1'b0;
            if (clear_i) state_d = SKID_EMPTY;
            else case (state_q)
                SKID_EMPTY: begin
                    state_d   = accept ? SKID_ONE : SKID_EMPTY;
                    load_main = accept;
                end
                SKID_ONE: begin
                    state_d   = accept ? (pop ? SKID_ONE : SKID_TWO) : (pop ? SKID_EMPTY : SKID_ONE);
                    load_main = accept && pop;
                    load_skid = accept && !pop;
                end
                SKID_TWO: begin
                    state_d   = pop ? SKID_ONE : SKID_TWO;
                    from_skid = pop;
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni || clear_i) begin
                main_q      <= '0;
                main_strb_q <= '0;
                skid_q      <= '0;
                skid_strb_q <= '0;
            end else begin
                if (load_main) begin
                    main_q      <= in_data;
                    main_strb_q <= in_strb;
                end else if (from_skid) begin
                    main_q      <= skid_q;
                    main_strb_q <= skid_strb_q;
                end
                if (load_skid) begin
                    skid_q      <= in_data;
                    skid_strb_q <= in_strb;
                end
            end
        end
    end
endmodule

// File: rtl/hwpe_stream_pipe.sv
// hwpe_stream_pipe: chain of NB_STAGES elastic slices between push_i and pop_o
//  clk_i, rst_ni (async, active low), clear_i (sync flush, ignored with no stages)
//  push_i : input stream (sink), pop_o : output stream (source)
//  idle_o : every slice empty
module hwpe_stream_pipe
    import hwpe_stream_package::*;
#(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            NB_STAGES  = 1,
    parameter hwpe_stream_pipe_mode_t PIPE_MODE  = HWPE_STREAM_PIPE_FWD
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    hwpe_stream_intf_stream.sink   push_i,
    hwpe_stream_intf_stream.source pop_o,
    output logic                  idle_o
);
    if (DATA_WIDTH % 8 != 0) $error("DATA_WIDTH must be a multiple of 8");
    if ($bits(push_i.data) != DATA_WIDTH || $bits(pop_o.data) != DATA_WIDTH) $error("interface DATA_WIDTH mismatch");
    if (NB_STAGES > HWPE_STREAM_PIPE_MAX_STAGES) $error("NB_STAGES out of range");
    if (NB_STAGES == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = clk_i ^ rst_ni ^ clear_i;
        assign pop_o.valid   = push_i.valid;
        assign pop_o.data    = push_i.data;
        assign pop_o.strb    = push_i.strb;
        assign push_i.ready  = pop_o.ready;
        assign idle_o        = 1'b1;
    end else begin : g_chain
        logic [NB_STAGES:0]      v, r;
        logic [DATA_WIDTH-1:0]   d [NB_STAGES+1];
        logic [DATA_WIDTH/8-1:0] s [NB_STAGES+1];
        logic [NB_STAGES-1:0]    e;
        assign v[0]         = push_i.valid;
        assign d[0]         = push_i.data;
        assign s[0]         = push_i.strb;
        assign push_i.ready = r[0];
        assign pop_o.valid  = v[NB_STAGES];
        assign pop_o.data   = d[NB_STAGES];
        assign pop_o.strb   = s[NB_STAGES];
        assign r[NB_STAGES] = pop_o.ready;
        assign idle_o       = &e;
        for (genvar i = 0; i < NB_STAGES; i++) begin : g_stage
            hwpe_stream_pipe_stage #(
                .DATA_WIDTH(DATA_WIDTH),
                .PIPE_MODE (PIPE_MODE)
            ) u_stage (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .clear_i  (clear_i),
                .in_valid (v[i]),
                .in_data  (d[i]),
                .in_strb  (s[i]),
                .in_ready (r[i]),
                .out_valid(v[i+1]),
                .out_data (d[i+1]),
                .out_strb (s[i+1]),
                .out_ready(r[i+1]),
                .empty    (e[i])
            );
        end
    end
endmodule
